vga_timing_grid: RTL and testbench
==================================

Name: vga_timing_grid

Overview:
- Parametrised successor to the fixed-count VGA display comparator.
- Owns the horizontal and vertical counters and generates registered hsync/vsync, the active-video flag, and pixel coordinates.
- Adds a configurable GRID_COLS x GRID_ROWS grid-line overlay with cell indices, plus frame/line start pulses.
- Sits between the pixel-clock domain and the colour mux / DAC interface; the colour mux consumes grid_line as its selector.

Parameters:
- N, 10, counter/coordinate width minus 1 (all counters are N+1 bits).
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BACK, 48, horizontal back porch.
- V_VISIBLE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BACK, 33, vertical back porch.
- SYNC_POL, 0, asserted level of hsync/vsync.
- GRID_COLS, 3, grid columns (>=1).
- GRID_ROWS, 3, grid rows (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  pixel-clock enable; counters advance only when en=1
- hsync  out  1  horizontal sync, level SYNC_POL when asserted
- vsync  out  1  vertical sync, level SYNC_POL when asserted
- vga_blank  out  1  1 = active video (DAC BLANK_N convention), 0 = blanking
- pixel_x  out  N+1  current column, 0..H_TOTAL-1
- pixel_y  out  N+1  current line, 0..V_TOTAL-1
- grid_line  out  1  1 = current pixel lies on an interior grid line
- cell_col  out  N+1  grid column index of current pixel
- cell_row  out  N+1  grid row index of current pixel
- line_start  out  1  one-en-cycle pulse at pixel_x=0
- frame_start  out  1  one-en-cycle pulse at pixel_x=0, pixel_y=0

Behaviour:
- Derived values:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
  - CELL_W = H_VISIBLE/GRID_COLS; CELL_H = V_VISIBLE/GRID_ROWS (integer division).
- Region order, both axes: visible, front porch, sync, back porch; count 0 is the first visible pixel/line.
- All outputs are flops; every output in a given cycle describes the position (pixel_x, pixel_y) shown in that same cycle.
- Reset (async, effective immediately, mid-frame included):
  - pixel_x=0, pixel_y=0, cell_col=0, cell_row=0.
  - hsync=vsync=~SYNC_POL; vga_blank=0, grid_line=0, line_start=0, frame_start=0.
  - Internal cell sub-counters are cleared.
- First en=1 cycle after reset release presents (0,0): vga_blank=1, line_start=1, frame_start=1, grid_line=0 (CELL_W,CELL_H>1).
- Advance on en=1:
  - pixel_x increments; it wraps from H_TOTAL-1 to 0.
  - When pixel_x wraps, pixel_y increments; it wraps from V_TOTAL-1 to 0.
- Hold on en=0: all state and level outputs hold; line_start and frame_start are forced to 0.
- hsync asserted iff H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC. vsync is the same on pixel_y with the V parameters.
- vga_blank=1 iff pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.
- Column cells:
  - A sub-counter counts 0..CELL_W-1 across the visible line.
  - When it reaches CELL_W-1 and cell_col < GRID_COLS-1, cell_col increments and the sub-counter restarts.
  - In the last column, the sub-counter saturates; remainder pixels (H_VISIBLE mod CELL_W) belong to the last cell.
  - cell_col resets to 0 at pixel_x=0 and holds GRID_COLS-1 through horizontal blanking.
- Row cells: identical rule with CELL_H, stepping once per line at the line wrap; cell_row resets to 0 at pixel_y=0.
- grid_line = vga_blank AND (col_edge OR row_edge):
  - col_edge: column sub-counter = CELL_W-1 and cell_col < GRID_COLS-1.
  - row_edge: row sub-counter = CELL_H-1 and cell_row < GRID_ROWS-1.
  - Defaults give vertical lines at x=212 and x=425, horizontal lines at y=159 and y=319.
  - GRID_COLS=1 (or GRID_ROWS=1) produces no lines on that axis.
- Simultaneous x wrap and y wrap: frame_start and line_start both assert on the following (0,0) cycle.
- No multiply or divide in hardware beyond elaboration-time constants; compares are unsigned at N+1 bits.

Test Plan:
- Reset asserted mid-line at (500,200), then released, en=1 continuously -> outputs go to reset values asynchronously; first en cycle shows (0,0) with frame_start=1 and vga_blank=1.
- One full line with en=1 -> hsync asserted for pixel_x 656..751 only (SYNC_POL=0 means low); vga_blank falls at x=640; line_start pulses once per 800 cycles.
- Full frame -> vsync asserted for lines 490..491; frame_start pulses every 420000 en cycles; pixel_y wraps 524->0.
- Default grid -> grid_line=1 exactly at x in {212,425} on visible lines and on all visible x at y in {159,319}; cell_col=2 for x=426..639; cell_row=2 at y=479; grid_line=0 everywhere in blanking.
- en toggled 1,0,0,1 repeatedly -> coordinates advance only on en=1 cycles; start pulses never exceed one cycle and never appear while en=0.
- GRID_COLS=4, GRID_ROWS=1, H_VISIBLE=640 -> vertical lines at x=159, 319, 479; no horizontal lines; cell_row stays 0.

Source files
------------

// File: rtl/vga_timing_grid.sv
// Raster timing generator with grid-line overlay: counters, syncs, active flag, cell indices, start pulses.
// Outputs are registered and describe the position latched on the same en edge; en=0 freezes everything.
module vga_timing_grid #(
  parameter int   N         = 10,
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   GRID_COLS = 3,
  parameter int   GRID_ROWS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_blank,
  output logic [N:0] pixel_x,
  output logic [N:0] pixel_y,
  output logic       grid_line,
  output logic [N:0] cell_col,
  output logic [N:0] cell_row,
  output logic       line_start,
  output logic       frame_start
);

  localparam int W       = N + 1;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int CELL_W  = H_VISIBLE / GRID_COLS;
  localparam int CELL_H  = V_VISIBLE / GRID_ROWS;

  localparam logic [N:0] HT_M1  = W'(H_TOTAL - 1);
  localparam logic [N:0] VT_M1  = W'(V_TOTAL - 1);
  localparam logic [N:0] HV     = W'(H_VISIBLE);
  localparam logic [N:0] VV     = W'(V_VISIBLE);
  localparam logic [N:0] HS_BEG = W'(H_VISIBLE + H_FRONT);
  localparam logic [N:0] HS_END = W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [N:0] VS_BEG = W'(V_VISIBLE + V_FRONT);
  localparam logic [N:0] VS_END = W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [N:0] CW_M1  = W'(CELL_W - 1);
  localparam logic [N:0] CH_M1  = W'(CELL_H - 1);
  localparam logic [N:0] GC_M1  = W'(GRID_COLS - 1);
  localparam logic [N:0] GR_M1  = W'(GRID_ROWS - 1);
  localparam logic [N:0] ZERO   = '0;

  // Position (and its cell bookkeeping) to be presented on the next en edge
  logic [N:0] cx, cy, csub, cidx, rsub, ridx;
  logic [N:0] cx_n, cy_n, csub_n, cidx_n, rsub_n, ridx_n;

  logic h_wrap, v_wrap, col_edge, row_edge, active, hs_on, vs_on;

  always_comb begin
    h_wrap   = (cx == HT_M1);
    v_wrap   = (cy == VT_M1);
    col_edge = (csub == CW_M1) && (cidx < GC_M1);
    row_edge = (rsub == CH_M1) && (ridx < GR_M1);
    active   = (cx < HV) && (cy < VV);
    hs_on    = (cx >= HS_BEG) && (cx < HS_END);
    vs_on    = (cy >= VS_BEG) && (cy < VS_END);
  end

  always_comb begin
    cx_n = h_wrap ? ZERO : cx + 1'b1;
    cy_n = cy;
    if (h_wrap) begin
      cy_n = v_wrap ? ZERO : cy + 1'b1;
    end
  end

  // Sub-counter saturates in the last cell so the remainder joins it
  always_comb begin
    csub_n = csub;
    cidx_n = cidx;
    if (h_wrap) begin
      csub_n = '0;
      cidx_n = '0;
    end else if (col_edge) begin
      csub_n = '0;
      cidx_n = cidx + 1'b1;
    end else if (csub != CW_M1) begin
      csub_n = csub + 1'b1;
    end
  end

  always_comb begin
    rsub_n = rsub;
    ridx_n = ridx;
    if (h_wrap) begin
      if (v_wrap) begin
        rsub_n = '0;
        ridx_n = '0;
      end else if (row_edge) begin
        rsub_n = '0;
        ridx_n = ridx + 1'b1;
      end else if (rsub != CH_M1) begin
        rsub_n = rsub + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx   <= '0;
      cy   <= '0;
      csub <= '0;
      cidx <= '0;
      rsub <= '0;
      ridx <= '0;
    end else if (en) begin
      cx   <= cx_n;
      cy   <= cy_n;
      csub <= csub_n;
      cidx <= cidx_n;
      rsub <= rsub_n;
      ridx <= ridx_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      vga_blank   <= 1'b0;
      grid_line   <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      cell_col    <= '0;
      cell_row    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      vga_blank   <= active;
      grid_line   <= active && (col_edge || row_edge);
      pixel_x     <= cx;
      pixel_y     <= cy;
      cell_col    <= cidx;
      cell_row    <= ridx;
      line_start  <= (cx == ZERO);
      frame_start <= (cx == ZERO) && (cy == ZERO);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_grid.sv
// Bench for vga_timing_grid: three parameter sets against an arithmetic position model.
module tb_vga_timing_grid;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: defaults
  logic        a_hs, a_vs, a_bl, a_gl, a_ls, a_fs;
  logic [10:0] a_px, a_py, a_cc, a_cr;
  // Instance 1: default timing, 4x1 grid
  logic        b_hs, b_vs, b_bl, b_gl, b_ls, b_fs;
  logic [10:0] b_px, b_py, b_cc, b_cr;
  // Instance 2: tiny raster so whole frames fit in the run
  logic        c_hs, c_vs, c_bl, c_gl, c_ls, c_fs;
  logic [7:0]  c_px, c_py, c_cc, c_cr;

  vga_timing_grid u_a (
    .clk(clk), .rst(rst), .en(en),
    .hsync(a_hs), .vsync(a_vs), .vga_blank(a_bl), .pixel_x(a_px), .pixel_y(a_py),
    .grid_line(a_gl), .cell_col(a_cc), .cell_row(a_cr), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_grid #(.GRID_COLS(4), .GRID_ROWS(1)) u_b (
    .clk(clk), .rst(rst), .en(en),
    .hsync(b_hs), .vsync(b_vs), .vga_blank(b_bl), .pixel_x(b_px), .pixel_y(b_py),
    .grid_line(b_gl), .cell_col(b_cc), .cell_row(b_cr), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_grid #(
    .N(7), .H_VISIBLE(43), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
    .SYNC_POL(1'b1), .GRID_COLS(3), .GRID_ROWS(2)
  ) u_c (
    .clk(clk), .rst(rst), .en(en),
    .hsync(c_hs), .vsync(c_vs), .vga_blank(c_bl), .pixel_x(c_px), .pixel_y(c_py),
    .grid_line(c_gl), .cell_col(c_cc), .cell_row(c_cr), .line_start(c_ls), .frame_start(c_fs)
  );

  int checks = 0;
  int errors = 0;
  int n      = 0;   // en edges accepted since reset
  bit le     = 1'b0; // en value at the most recent edge

  typedef struct {
    int px, py, hs, vs, bl, gl, cc, cr, ls, fs;
  } exp_t;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Position p = n-1 maps straight to (x,y); everything else follows arithmetically.
  function automatic exp_t model(input int c, input int cnt, input bit last_en);
    int hv, hf, hs, hb, vv, vf, vs, vb, pol, gc, gr;
    int ht, vt, cw, ch, p, x, y;
    exp_t e;
    hv = 640; hf = 16; hs = 96; hb = 48;
    vv = 480; vf = 10; vs = 2;  vb = 33;
    pol = 0; gc = 3; gr = 3;
    if (c == 1) begin
      gc = 4; gr = 1;
    end
    if (c == 2) begin
      hv = 43; hf = 4; hs = 6; hb = 5;
      vv = 20; vf = 2; vs = 3; vb = 4;
      pol = 1; gc = 3; gr = 2;
    end
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    cw = hv / gc;
    ch = vv / gr;
    if (cnt == 0) begin
      e = '{0, 0, 1 - pol, 1 - pol, 0, 0, 0, 0, 0, 0};
      return e;
    end
    p = cnt - 1;
    x = p % ht;
    y = (p / ht) % vt;
    e.px = x;
    e.py = y;
    e.hs = (x >= hv + hf && x < hv + hf + hs) ? pol : 1 - pol;
    e.vs = (y >= vv + vf && y < vv + vf + vs) ? pol : 1 - pol;
    e.bl = (x < hv && y < vv) ? 1 : 0;
    e.cc = imin(x / cw, gc - 1);
    e.cr = imin(y / ch, gr - 1);
    e.gl = (e.bl == 1 &&
            ((x % cw == cw - 1 && x / cw < gc - 1) ||
             (y % ch == ch - 1 && y / ch < gr - 1))) ? 1 : 0;
    e.ls = (last_en && x == 0) ? 1 : 0;
    e.fs = (last_en && x == 0 && y == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check_dut(input int c, input int px, input int py, input int hs, input int vs,
                           input int bl, input int gl, input int cc, input int cr,
                           input int ls, input int fs);
    exp_t e;
    e = model(c, n, le);
    check_val($sformatf("d%0d_pixel_x", c), px, e.px);
    check_val($sformatf("d%0d_pixel_y", c), py, e.py);
    check_val($sformatf("d%0d_hsync", c), hs, e.hs);
    check_val($sformatf("d%0d_vsync", c), vs, e.vs);
    check_val($sformatf("d%0d_vga_blank", c), bl, e.bl);
    check_val($sformatf("d%0d_grid_line", c), gl, e.gl);
    check_val($sformatf("d%0d_cell_col", c), cc, e.cc);
    check_val($sformatf("d%0d_cell_row", c), cr, e.cr);
    check_val($sformatf("d%0d_line_start", c), ls, e.ls);
    check_val($sformatf("d%0d_frame_start", c), fs, e.fs);
  endtask

  task automatic check_all();
    check_dut(0, int'(a_px), int'(a_py), int'(a_hs), int'(a_vs), int'(a_bl), int'(a_gl),
              int'(a_cc), int'(a_cr), int'(a_ls), int'(a_fs));
    check_dut(1, int'(b_px), int'(b_py), int'(b_hs), int'(b_vs), int'(b_bl), int'(b_gl),
              int'(b_cc), int'(b_cr), int'(b_ls), int'(b_fs));
    check_dut(2, int'(c_px), int'(c_py), int'(c_hs), int'(c_vs), int'(c_bl), int'(c_gl),
              int'(c_cc), int'(c_cr), int'(c_ls), int'(c_fs));
  endtask

  // Called just after a falling edge: drive en, take one rising edge, check at the next falling edge.
  task automatic cycle(input bit en_v);
    en = en_v;
    @(posedge clk);
    if (rst) begin
      n  = 0;
      le = 1'b0;
    end else begin
      if (en) n++;
      le = en;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0);
    cycle(1'b0);

    for (int i = 0; i < 2000; i++) cycle(1'b1);
    for (int i = 0; i < 400; i++) cycle((i % 4 == 0) || (i % 4 == 3));
    for (int i = 0; i < 4000; i++) cycle(($urandom % 4) != 0);

    // Asynchronous reset between clock edges, mid-line and mid-frame
    #2 rst = 1'b1;
    #1 n = 0;
    le = 1'b0;
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int i = 0; i < 4000; i++) cycle(1'b1);
    for (int i = 0; i < 200; i++) cycle(($urandom % 2) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
